ads8505_capture: RTL and testbench
==================================

ADS8505_CAPTURE -- requirements
Module: ads8505_capture

Interface
REQ-001 Parameters SHALL be:
  ACCESS_CYC  5    clk cycles adc_cs_n is held low before adc_data is latched (>=1)
  TIMEOUT_CYC 400  max clk cycles from conversion start to BUSY rise (8 us at 50 MHz)
  OFFSET_BIN  0    1 = invert adc_data[15] (two's complement -> offset binary)
REQ-002 Ports SHALL be (name direction width meaning):
  clk          in   1   system clock, 50 MHz; rst_n asynchronous, active-low
  rst_n        in   1   reset
  adc_rc       in   1   R/C from conversion generator, same clk domain, low = convert
  adc_busy     in   1   ADS8505 BUSY pin, asynchronous, high = data ready
  adc_data     in   16  ADS8505 parallel data bus, asynchronous
  adc_cs_n     out  1   ADS8505 chip select, active-low
  s_data       out  16  captured sample
  s_valid      out  1   s_data valid
  s_ready      in   1   downstream accepts s_data
  s_count      out  16  captured-sample counter
  overrun      out  1   sticky: unaccepted sample overwritten
  timeout_err  out  1   sticky: BUSY did not rise within TIMEOUT_CYC
  clr_err      in   1   synchronous clear of overrun and timeout_err

Function
REQ-003 adc_busy SHALL pass through a 2-FF synchronizer; a rise SHALL be synchronized-high with previous synchronized-low.
REQ-004 A conversion start SHALL be adc_rc high in previous cycle and low in current cycle.
REQ-005 FSM states SHALL be IDLE, CONV, ACCESS.
REQ-006 IDLE: on conversion start -> CONV, timer cleared; adc_cs_n = 1.
REQ-007 CONV: on BUSY rise -> ACCESS, cycle counter cleared; else when timer reaches TIMEOUT_CYC-1 -> IDLE and timeout_err set.
REQ-008 ACCESS: adc_cs_n SHALL be 0 for exactly ACCESS_CYC cycles; on last cycle adc_data SHALL be latched into s_data, s_count incremented, s_valid set, state -> IDLE.
REQ-009 adc_cs_n SHALL be driven from a register (glitch-free).
REQ-010 s_valid SHALL assert 2+ACCESS_CYC rising edges after the edge first sampling adc_busy high (7 at default).
REQ-011 Conversion starts in CONV or ACCESS SHALL be ignored.
REQ-012 s_valid SHALL clear on the cycle after s_valid && s_ready, unless a new sample is latched in that same cycle, in which case s_valid stays 1 with new data and overrun is not set.
REQ-013 Latching while s_valid && !s_ready SHALL overwrite s_data and set overrun.
REQ-014 OFFSET_BIN=1: s_data[15] = ~adc_data[15], bits 14:0 unchanged.
REQ-015 s_count SHALL wrap 0xFFFF -> 0x0000.
REQ-016 clr_err SHALL clear both flags; a set event in the same cycle SHALL take priority.

Reset
REQ-017 On rst_n low: state IDLE, adc_cs_n 1, s_data 0, s_valid 0, s_count 0, overrun 0, timeout_err 0, synchronizer and timers 0.
REQ-018 Reset mid-ACCESS SHALL release adc_cs_n immediately (asynchronous) and discard the sample.

Structure
REQ-019 Package ads8505_pkg SHALL hold the FSM state type and default ACCESS_CYC/TIMEOUT_CYC constants.
REQ-020 Synchronizer SHALL be sub-module sync_2ff; rest is flat.

Verification
REQ-021 adc_rc falls, adc_busy rises 200 cycles later, adc_data=0x8001, s_ready=1 -> cs_n low 5 cycles, s_data=0x8001, s_valid pulse 1 cycle, s_count=1.
REQ-022 OFFSET_BIN=1, adc_data=0x8001 -> s_data=0x0001; adc_data=0x7FFF -> 0xFFFF.
REQ-023 adc_rc falls, adc_busy stays low -> timeout_err=1 after 400 cycles, no cs_n pulse; clr_err -> 0.
REQ-024 s_ready=0, two conversions (0x1111, 0x2222) -> s_data=0x2222, overrun=1, s_valid held.
REQ-025 rst_n low during ACCESS -> cs_n=1 at once, s_valid=0, next conversion captures normally.
REQ-026 s_count preloaded by 65535 conversions, one more -> s_count=0x0000.

Source files
------------

// File: rtl/ads8505_pkg.sv
// ads8505_pkg: FSM state type and default access/timeout constants shared by ads8505_capture
package ads8505_pkg;
  typedef enum logic [1:0] {IDLE, CONV, ACCESS} state_t;
  localparam int ACCESS_CYC_DEF = 5;
  localparam int TIMEOUT_CYC_DEF = 400;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous bit (clk, rst_n async low, d in, q out)
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, m} <= 2'b00;
    else {q, m} <= {m, d};
endmodule

// File: rtl/ads8505_capture.sv
// ads8505_capture: ADS8505 readout (adc_rc/adc_busy/adc_data in, adc_cs_n out) feeding s_data/s_valid/s_ready with s_count, sticky overrun/timeout_err, clr_err
module ads8505_capture
  import ads8505_pkg::*;
#(
  parameter int ACCESS_CYC  = ACCESS_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int OFFSET_BIN  = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        adc_rc,
  input  logic        adc_busy,
  input  logic [15:0] adc_data,
  output logic        adc_cs_n,
  output logic [15:0] s_data,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [15:0] s_count,
  output logic        overrun,
  output logic        timeout_err,
  input  logic        clr_err
);
  localparam int AW = ACCESS_CYC > 1 ? $clog2(ACCESS_CYC) : 1;
  localparam int TW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
  state_t state, nxt;
  logic busy_s, busy_d, rc_d, rise, start, latch, tmo;
  logic [AW-1:0] cnt;
  logic [TW-1:0] tmr;
  sync_2ff u_sync (.clk(clk), .rst_n(rst_n), .d(adc_busy), .q(busy_s));
  assign rise  = busy_s & ~busy_d;
  assign start = rc_d & ~adc_rc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE ? (start ? CONV : IDLE) :
          state == CONV ? (rise ? ACCESS : tmo ? IDLE : CONV) :
          (latch ? IDLE : ACCESS);
  always_comb begin
    latch = state == ACCESS && cnt == AW'(ACCESS_CYC - 1);
    tmo   = state == CONV && !rise && tmr == TW'(TIMEOUT_CYC - 1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy_d      <= 1'b0;
      rc_d        <= 1'b0;
      tmr         <= '0;
      cnt         <= '0;
      adc_cs_n    <= 1'b1;
      s_data      <= '0;
      s_valid     <= 1'b0;
      s_count     <= '0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      busy_d      <= busy_s;
      rc_d        <= adc_rc;
      tmr         <= state == CONV ? tmr + TW'(1) : '0;
      cnt         <= state == ACCESS ? cnt + AW'(1) : '0;
      adc_cs_n    <= nxt != ACCESS;
      s_data      <= latch ? {adc_data[15] ^ (OFFSET_BIN != 0), adc_data[14:0]} : s_data;
      s_count     <= latch ? s_count + 16'd1 : s_count;
      s_valid     <= latch | (s_valid & ~s_ready);
      overrun     <= (latch & s_valid & ~s_ready) | (overrun & ~clr_err);
      timeout_err <= tmo | (timeout_err & ~clr_err);
    end
endmodule

// File: tb/tb_ads8505_capture.sv
// tb_ads8505_capture: directed vector bench for ads8505_capture (plain and offset-binary instances)
module tb_ads8505_capture;
  logic clk = 1'b0, rst_n = 1'b0, adc_rc = 1'b1, adc_busy = 1'b0, s_ready = 1'b1, clr_err = 1'b0;
  logic [15:0] adc_data = '0;
  logic cs_n, s_valid, overrun, timeout_err;
  logic [15:0] s_data, s_count;
  logic ob_cs_n, ob_valid, ob_overrun, ob_timeout;
  logic [15:0] ob_data, ob_count;
  int checks = 0, fails = 0;
  ads8505_capture dut (
    .clk(clk), .rst_n(rst_n), .adc_rc(adc_rc), .adc_busy(adc_busy), .adc_data(adc_data),
    .adc_cs_n(cs_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_count(s_count),
    .overrun(overrun), .timeout_err(timeout_err), .clr_err(clr_err)
  );
  ads8505_capture #(.OFFSET_BIN(1)) dut_ob (
    .clk(clk), .rst_n(rst_n), .adc_rc(adc_rc), .adc_busy(adc_busy), .adc_data(adc_data),
    .adc_cs_n(ob_cs_n), .s_data(ob_data), .s_valid(ob_valid), .s_ready(s_ready), .s_count(ob_count),
    .overrun(ob_overrun), .timeout_err(ob_timeout), .clr_err(clr_err)
  );
  always #10 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic conv(input logic [15:0] d, input int dly, input int ready_at,
                      output int lows, output int first, output int vcyc);
    adc_data = d;
    @(negedge clk) adc_rc = 1'b1;
    @(negedge clk) adc_rc = 1'b0;
    repeat (dly) @(negedge clk);
    adc_busy = 1'b1;
    lows = 0;
    first = -1;
    vcyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!cs_n) lows++;
      if (s_valid) begin
        vcyc++;
        if (first < 0) first = i;
      end
      if (i == ready_at) s_ready = 1'b1;
    end
    adc_busy = 1'b0;
  endtask
  typedef struct {
    logic [15:0] d;
    int          dly;
    logic [15:0] exp;
    logic [15:0] exp_ob;
  } vec_t;
  vec_t v[4];
  int lows, first, vcyc, tlows;
  logic [15:0] exp_cnt;
  initial begin
    v[0] = '{16'h8001, 200, 16'h8001, 16'h0001};
    v[1] = '{16'h7FFF, 5,   16'h7FFF, 16'hFFFF};
    v[2] = '{16'h0000, 1,   16'h0000, 16'h8000};
    v[3] = '{16'hA5C3, 398, 16'hA5C3, 16'h25C3};
    repeat (3) @(negedge clk);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_valid", s_valid, 0);
    chk("rst_data", s_data, 0);
    chk("rst_count", s_count, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_timeout", timeout_err, 0);
    rst_n = 1'b1;
    exp_cnt = 16'd0;
    for (int i = 0; i < 4; i++) begin
      conv(v[i].d, v[i].dly, -1, lows, first, vcyc);
      exp_cnt++;
      chk($sformatf("v%0d_cs_low", i), lows, 5);
      chk($sformatf("v%0d_latency", i), first, 7);
      chk($sformatf("v%0d_pulse", i), vcyc, 1);
      chk($sformatf("v%0d_data", i), s_data, v[i].exp);
      chk($sformatf("v%0d_data_ob", i), ob_data, v[i].exp_ob);
      chk($sformatf("v%0d_count", i), s_count, exp_cnt);
      chk($sformatf("v%0d_timeout", i), timeout_err, 0);
    end
    tlows = 0;
    @(negedge clk) adc_rc = 1'b1;
    @(negedge clk) adc_rc = 1'b0;
    for (int i = 1; i <= 401; i++) begin
      @(negedge clk);
      if (!cs_n) tlows++;
      if (i == 400) chk("tmo_before", timeout_err, 0);
      if (i == 401) chk("tmo_set", timeout_err, 1);
    end
    chk("tmo_no_cs", tlows, 0);
    chk("tmo_count", s_count, exp_cnt);
    clr_err = 1'b1;
    @(negedge clk) clr_err = 1'b0;
    chk("tmo_clr", timeout_err, 0);
    s_ready = 1'b0;
    conv(16'h1111, 10, -1, lows, first, vcyc);
    chk("ovr1_valid", s_valid, 1);
    chk("ovr1_flag", overrun, 0);
    conv(16'h2222, 10, -1, lows, first, vcyc);
    exp_cnt += 16'd2;
    chk("ovr2_cs_low", lows, 5);
    chk("ovr2_data", s_data, 16'h2222);
    chk("ovr2_flag", overrun, 1);
    chk("ovr2_valid", s_valid, 1);
    chk("ovr2_count", s_count, exp_cnt);
    s_ready = 1'b1;
    @(negedge clk);
    chk("ovr_drain", s_valid, 0);
    clr_err = 1'b1;
    @(negedge clk) clr_err = 1'b0;
    chk("ovr_clr", overrun, 0);
    s_ready = 1'b0;
    conv(16'h3333, 10, -1, lows, first, vcyc);
    conv(16'h4444, 10, 6, lows, first, vcyc);
    exp_cnt += 16'd2;
    chk("same_cyc_valid_run", vcyc, 8);
    chk("same_cyc_data", s_data, 16'h4444);
    chk("same_cyc_overrun", overrun, 0);
    chk("same_cyc_valid_end", s_valid, 0);
    adc_data = 16'h5555;
    @(negedge clk) adc_rc = 1'b1;
    @(negedge clk) adc_rc = 1'b0;
    repeat (10) @(negedge clk);
    adc_busy = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid_access_cs", cs_n, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_cs", cs_n, 1);
    chk("rst_async_valid", s_valid, 0);
    chk("rst_async_count", s_count, 0);
    adc_busy = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_discard_valid", s_valid, 0);
    conv(16'h6666, 10, -1, lows, first, vcyc);
    chk("post_rst_cs_low", lows, 5);
    chk("post_rst_data", s_data, 16'h6666);
    chk("post_rst_count", s_count, 1);
    @(negedge clk) force dut.s_count = 16'hFFFF;
    #1 release dut.s_count;
    @(negedge clk);
    chk("preload_count", s_count, 16'hFFFF);
    conv(16'h0F0F, 10, -1, lows, first, vcyc);
    chk("wrap_count", s_count, 16'h0000);
    chk("wrap_data", s_data, 16'h0F0F);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
